// File: rtl/shift_arbiter.sv
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Two-requester arbiter sharing one 32-bit shifter (IDLE/EXEC/RESP).
//            Define SHIFT_ARB_RR_EN for round-robin grant; else requester 0 wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_op,
  input  logic [1:0][4:0]       req_sh,
  input  logic [1:0][4:0]       req_maskbits,
  input  logic [1:0]            req_left,
  input  logic [1:0]            req_sx,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_op;
  logic [4:0]       r_sh;
  logic [4:0]       r_maskbits;
  logic             r_left;
  logic             r_sx;
  logic [TAG_W-1:0] r_tag;
  logic             r_id;

  logic             w_gnt;
  logic             w_open;
  logic             w_take;
  logic [31:0]      w_shr;
  logic [31:0]      w_shl;
  logic [31:0]      w_mask;
  logic [31:0]      w_shift;

`ifdef SHIFT_ARB_RR_EN
  // Pointer holds the last granted requester; reset to 1 so requester 0 goes first.
  logic r_ptr;

  assign w_gnt = (&req_valid) ? ~r_ptr : req_valid[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b1;
    end else if (w_take) begin
      r_ptr <= w_gnt;
    end
  end
`else
  assign w_gnt = ~req_valid[0];
`endif

  // A slot opens in IDLE, or in RESP on the same cycle the response is consumed.
  assign w_open    = rst_n && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_take    = w_open && (|req_valid);
  assign req_ready = w_take ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  // The single shared shifter, fed only from the operand registers.
  assign w_shr   = r_sx ? 32'($signed(r_op) >>> r_sh) : (r_op >> r_sh);
  assign w_shl   = r_op << r_sh;
  assign w_mask  = (r_maskbits == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << r_maskbits) - 32'd1);
  assign w_shift = (r_left ? w_shl : w_shr) & w_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_sh       <= '0;
      r_maskbits <= '0;
      r_left     <= 1'b0;
      r_sx       <= 1'b0;
      r_tag      <= '0;
      r_id       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (w_take) begin
        r_op       <= req_op[w_gnt];
        r_sh       <= req_sh[w_gnt];
        r_maskbits <= req_maskbits[w_gnt];
        r_left     <= req_left[w_gnt];
        r_sx       <= req_sx[w_gnt];
        r_tag      <= req_tag[w_gnt];
        r_id       <= w_gnt;
      end
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= w_shift;
          rsp_id    <= r_id;
          rsp_tag   <= r_tag;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= w_take ? EXEC : IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module   : tb_shift_arbiter
// Purpose  : Directed scoreboard bench for shift_arbiter (either grant mode).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      data;
    logic             id;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_op;
  logic [1:0][4:0]       req_sh;
  logic [1:0][4:0]       req_maskbits;
  logic [1:0]            req_left;
  logic [1:0]            req_sx;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_id;
  logic [TAG_W-1:0]      rsp_tag;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   cyc   = 0;
  logic auto_drop;
  logic [1:0] acc;
  exp_t sb[$];
  int   rsp_ids[$];
  int   rsp_cyc[$];

  shift_arbiter #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_sh       (req_sh),
    .req_maskbits (req_maskbits),
    .req_left     (req_left),
    .req_sx       (req_sx),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .rsp_tag      (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Bit-by-bit reference shifter.
  function automatic logic [31:0] model(input logic [31:0] op, input logic [4:0] sh,
                                        input logic [4:0] mb, input logic left, input logic sx);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      src = left ? (i - int'(sh)) : (i + int'(sh));
      if (src >= 0 && src < 32) r[i] = op[src];
      else                      r[i] = (!left && sx) ? op[31] : 1'b0;
      if (mb != 5'd0 && i >= int'(mb)) r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] op, input logic [4:0] sh,
                         input logic [4:0] mb, input logic left, input logic sx,
                         input logic [TAG_W-1:0] tag);
    req_op[k]       = op;
    req_sh[k]       = sh;
    req_maskbits[k] = mb;
    req_left[k]     = left;
    req_sx[k]       = sx;
    req_tag[k]      = tag;
  endtask

  // Mid-cycle observation: push on accept, pop and compare on response handshake.
  task automatic sample();
    exp_t e;
    int   k;
    @(negedge clk);
    cyc++;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    acc = req_valid & req_ready;
    if (acc != 2'b00) begin
      k = acc[1] ? 1 : 0;
      e.data = model(req_op[k], req_sh[k], req_maskbits[k], req_left[k], req_sx[k]);
      e.id   = acc[1];
      e.tag  = req_tag[k];
      sb.push_back(e);
      n_acc++;
    end
    if (rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", rsp_data, e.data);
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_tag", 32'(rsp_tag), 32'(e.tag));
      end
      rsp_ids.push_back(int'(rsp_id));
      rsp_cyc.push_back(cyc);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_data"},  rsp_data, 32'd0);
    chk({tag, "_id"},    32'(rsp_id), 32'd0);
    chk({tag, "_tag"},   32'(rsp_tag), 32'd0);
  endtask

  logic [31:0]      d0;
  logic             i0;
  logic [TAG_W-1:0] t0;
  int               a0;
  int               exp_ids[4];

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    auto_drop = 1'b1;
    acc       = 2'b00;
    set_req(0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    set_req(1, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, '0);

    // Reset state with requests pending
    repeat (2) begin sample(); chk_zero("reset"); advance(); end
    rst_n     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    sample(); advance();

    // Requester 0 logical right shift, latency check
    set_req(0, 32'h8000_00F0, 5'd4, 5'd0, 1'b0, 1'b0, 4'd3);
    req_valid = 2'b01;
    sample(); chk("t1_ready", 32'(req_ready), 32'h1); advance();
    sample(); chk("t1_valid_exec", 32'(rsp_valid), 32'd0); advance();
    sample();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data", rsp_data, 32'h0800_000F);
    chk("t1_id", 32'(rsp_id), 32'd0);
    chk("t1_tag", 32'(rsp_tag), 32'd3);
    advance();

    // Requester 1 left shift with sign-extend set
    set_req(1, 32'h0000_0080, 5'd24, 5'd0, 1'b1, 1'b1, 4'd5);
    req_valid = 2'b10;
    sample(); chk("t2_ready", 32'(req_ready), 32'h2); advance();
    sample(); advance();
    sample();
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_data", rsp_data, 32'h8000_0000);
    chk("t2_id", 32'(rsp_id), 32'd1);
    advance();

    // Stall in RESP with another request pending
    rsp_ready = 1'b0;
    set_req(0, 32'hF000_1234, 5'd8, 5'd16, 1'b0, 1'b1, 4'd9);
    req_valid = 2'b01;
    sample(); chk("t3_ready", 32'(req_ready), 32'h1); advance();
    set_req(1, 32'h0000_FFFF, 5'd31, 5'd0, 1'b1, 1'b0, 4'hA);
    req_valid = 2'b10;
    sample();
    chk("t3_exec_valid", 32'(rsp_valid), 32'd0);
    chk("t3_exec_ready", 32'(req_ready), 32'd0);
    advance();
    sample();
    d0 = rsp_data; i0 = rsp_id; t0 = rsp_tag;
    chk("t3_valid", 32'(rsp_valid), 32'd1);
    chk("t3_data_val", rsp_data, 32'h0000_0012);
    advance();
    repeat (5) begin
      sample();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, d0);
      chk("stall_id", 32'(rsp_id), 32'(i0));
      chk("stall_tag", 32'(rsp_tag), 32'(t0));
      chk("stall_ready", 32'(req_ready), 32'd0);
      advance();
    end
    rsp_ready = 1'b1;
    sample(); chk("release_ready", 32'(req_ready), 32'h2); advance();
    sample(); advance();
    sample();
    chk("t3b_valid", 32'(rsp_valid), 32'd1);
    chk("t3b_id", 32'(rsp_id), 32'd1);
    advance();

    // Both requesters valid continuously, back-to-back
    auto_drop = 1'b0;
    rsp_ids.delete();
    rsp_cyc.delete();
    set_req(0, 32'h1234_5678, 5'd3, 5'd0, 1'b1, 1'b0, 4'h1);
    set_req(1, 32'h8765_4321, 5'd7, 5'd12, 1'b0, 1'b1, 4'h2);
    req_valid = 2'b11;
    a0 = n_acc;
    for (int i = 0; i < 20 && rsp_ids.size() < 4; i++) begin
      sample();
      advance();
      if (n_acc - a0 >= 4) req_valid = 2'b00;
    end
`ifdef SHIFT_ARB_RR_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    chk("b2b_count", 32'(rsp_ids.size()), 32'd4);
    if (rsp_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("b2b_id%0d", i), 32'(rsp_ids[i]), 32'(exp_ids[i]));
      for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd2);
    end
    auto_drop = 1'b1;
    sample(); advance();

    // Reset pulsed during EXEC discards the request
    set_req(0, 32'hDEAD_BEEF, 5'd1, 5'd0, 1'b0, 1'b0, 4'h7);
    req_valid = 2'b01;
    sample(); chk("t5_ready", 32'(req_ready), 32'h1); advance();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    sb.delete();
    repeat (2) begin sample(); chk_zero("midrst"); advance(); end
    rst_n     = 1'b1;
    req_valid = 2'b00;
    repeat (4) begin sample(); chk("post_rst_valid", 32'(rsp_valid), 32'd0); advance(); end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
